// File: rtl/fifo_sc_m.sv
// Single-clock FIFO on inferred storage with standard or first-word-fall-through
// read mode, fixed and programmable occupancy flags, and reject strobes.
module fifo_sc_m #(
  parameter type DATA_ITEM_TYPE    = logic,
  parameter int  DEPTH             = 32,
  parameter bit  FWFT              = 1'b1,
  parameter int  PROG_FULL_THRESH  = DEPTH - 2,
  parameter int  PROG_EMPTY_THRESH = 2,
  localparam int DATA_COUNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  DATA_ITEM_TYPE           tail,
  input  logic                    push,
  output DATA_ITEM_TYPE           head,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    prog_full,
  output logic                    prog_empty,
  output logic [DATA_COUNT_W-1:0] data_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_COUNT_W-1:0] DEPTH_C = DATA_COUNT_W'(DEPTH);
  localparam logic [DATA_COUNT_W-1:0] AF_C    = DATA_COUNT_W'(DEPTH - 1);
  localparam logic [DATA_COUNT_W-1:0] ONE_C   = DATA_COUNT_W'(1);
  localparam logic [DATA_COUNT_W-1:0] PF_C    = DATA_COUNT_W'(PROG_FULL_THRESH);
  localparam logic [DATA_COUNT_W-1:0] PE_C    = DATA_COUNT_W'(PROG_EMPTY_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sc_m: DEPTH must be a power of two and at least 4");
  end
  if ((PROG_FULL_THRESH < 1) || (PROG_FULL_THRESH > DEPTH)) begin : g_bad_pf
    $error("fifo_sc_m: PROG_FULL_THRESH must lie in 1..DEPTH");
  end
  if ((PROG_EMPTY_THRESH < 0) || (PROG_EMPTY_THRESH > DEPTH - 1)) begin : g_bad_pe
    $error("fifo_sc_m: PROG_EMPTY_THRESH must lie in 0..DEPTH-1");
  end

  DATA_ITEM_TYPE           mem [DEPTH];
  DATA_ITEM_TYPE           head_nxt;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           rd_ptr_nxt;
  logic [DATA_COUNT_W-1:0] count_nxt;
  logic                    pop_ok;
  logic                    push_ok;

  // A pop frees a slot in the same cycle, so a push on full still fits.
  always_comb begin
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop_ok);
    rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = data_count;
    if (push_ok && !pop_ok) begin
      count_nxt = data_count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = data_count - 1'b1;
    end
  end

  if (FWFT) begin : g_fwft
    // head mirrors the oldest item; tail bypasses storage when it becomes the head.
    always_comb begin
      head_nxt = head;
      if (data_count == '0) begin
        if (push_ok) begin
          head_nxt = tail;
        end
      end else if (pop_ok) begin
        if (data_count == ONE_C) begin
          if (push_ok) begin
            head_nxt = tail;
          end
        end else begin
          head_nxt = mem[rd_ptr_nxt];
        end
      end
    end
  end else begin : g_std
    always_comb begin
      head_nxt = head;
      if (pop_ok) begin
        head_nxt = mem[rd_ptr];
      end
    end
  end

  // Storage write port; contents are left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= tail;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      head         <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      prog_full    <= 1'b0;
      prog_empty   <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr       <= rd_ptr_nxt;
      data_count   <= count_nxt;
      head         <= head_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= ONE_C);
      prog_full    <= (count_nxt >= PF_C);
      prog_empty   <= (count_nxt <= PE_C);
      overflow     <= push && !push_ok;
      underflow    <= pop && empty;
    end
  end

endmodule
